// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: bundles the instruction-fetch port, the data-access
// port and the single-ported SRAM port that sram_port_arbiter sits between.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever drives the requesters and models the SRAM macro.
interface sram_port_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_gnt;
  logic        inst_stall;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_stall;
  logic        data_rvalid;
  logic [31:0] data_rdata;

  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  modport slave (
    input  inst_req, inst_addr,
    output inst_gnt, inst_stall, inst_rvalid, inst_rdata,
    input  data_req, data_wen, data_addr, data_wdata,
    output data_gnt, data_stall, data_rvalid, data_rdata,
    output sram_en, sram_wen, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_gnt, inst_stall, inst_rvalid, inst_rdata,
    output data_req, data_wen, data_addr, data_wdata,
    input  data_gnt, data_stall, data_rvalid, data_rdata,
    input  sram_en, sram_wen, sram_addr, sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-ported synchronous SRAM between the
// CPU instruction-fetch port and data-access port. One grant per cycle,
// data wins by default, read data comes back one cycle after the grant and
// is routed to the port that issued it.
// Optional feature macro: ARB_STARVE_GUARD_EN. When defined, an instruction
// request that has lost MAX_DATA_BURST consecutive cycles to data is forced
// to win; when undefined, data has strict priority.
module sram_port_arbiter #(
  parameter int unsigned MAX_DATA_BURST = 4
) (
  input  logic                clk,
  input  logic                resetn,
  sram_port_arbiter_if.slave  bus
);

  if (MAX_DATA_BURST < 1 || MAX_DATA_BURST > 15) begin : g_bad_burst
    $error("sram_port_arbiter: MAX_DATA_BURST must be in 1..15");
  end

  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_INST = 2'd1,
    PEND_DATA = 2'd2
  } pend_e;

  pend_e       pend_q, pend_d;
  logic [31:0] inst_hold_q, inst_hold_d;
  logic [31:0] data_hold_q, data_hold_d;
  logic        inst_gnt;
  logic        data_gnt;
  logic        inst_force;
  logic        inst_rvalid;
  logic        data_rvalid;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] BURST_MAX = 4'(MAX_DATA_BURST);

  logic [3:0] starve_cnt_q, starve_cnt_d;

  assign inst_force = bus.inst_req && (starve_cnt_q == BURST_MAX);

  // Count consecutive cycles a waiting instruction request loses to data
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.inst_req || inst_gnt) begin
      starve_cnt_d = 4'd0;
    end else if (data_gnt && (starve_cnt_q != BURST_MAX)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt_q <= 4'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign inst_force = 1'b0;
`endif

  // Pick at most one winner; nothing is granted while reset is held
  always_comb begin
    inst_gnt = 1'b0;
    data_gnt = 1'b0;
    if (resetn) begin
      if (bus.data_req && !inst_force) begin
        data_gnt = 1'b1;
      end else if (bus.inst_req) begin
        inst_gnt = 1'b1;
      end
    end
  end

  // Drive grants, stalls, the SRAM port and the read-return paths
  always_comb begin
    inst_rvalid    = (pend_q == PEND_INST);
    data_rvalid    = (pend_q == PEND_DATA);

    bus.inst_gnt   = inst_gnt;
    bus.data_gnt   = data_gnt;
    bus.inst_stall = resetn & bus.inst_req & ~inst_gnt;
    bus.data_stall = resetn & bus.data_req & ~data_gnt;

    bus.sram_en    = inst_gnt | data_gnt;
    bus.sram_wen   = data_gnt ? bus.data_wen : 4'b0000;
    bus.sram_addr  = 32'h0;
    bus.sram_wdata = 32'h0;
    if (data_gnt) begin
      bus.sram_addr  = bus.data_addr;
      bus.sram_wdata = bus.data_wdata;
    end else if (inst_gnt) begin
      bus.sram_addr  = bus.inst_addr;
    end

    bus.inst_rvalid = inst_rvalid;
    bus.data_rvalid = data_rvalid;
    bus.inst_rdata  = inst_rvalid ? bus.sram_rdata : inst_hold_q;
    bus.data_rdata  = data_rvalid ? bus.sram_rdata : data_hold_q;
  end

  // Tag the outstanding read and capture returned data into the hold registers
  always_comb begin
    pend_d      = PEND_NONE;
    inst_hold_d = inst_hold_q;
    data_hold_d = data_hold_q;
    if (inst_gnt) begin
      pend_d = PEND_INST;
    end else if (data_gnt && (bus.data_wen == 4'b0000)) begin
      pend_d = PEND_DATA;
    end
    if (inst_rvalid) begin
      inst_hold_d = bus.sram_rdata;
    end
    if (data_rvalid) begin
      data_hold_d = bus.sram_rdata;
    end
  end

  // Pending tag and hold registers; reset drops any read in flight
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_q      <= PEND_NONE;
      inst_hold_q <= 32'h0;
      data_hold_q <= 32'h0;
    end else begin
      pend_q      <= pend_d;
      inst_hold_q <= inst_hold_d;
      data_hold_q <= data_hold_d;
    end
  end

endmodule
